// File: rtl/multi_tone_dds.sv
`default_nettype none
// ============================================================================
//  Module   : multi_tone_dds
//  Purpose  : N-channel DDS tone generator. Each channel has a programmable
//             phase increment, an enable, a phase accumulator and a
//             quarter-wave sine ROM. Per-channel samples and their
//             width-grown sum are presented together with a valid flag.
//  Revision : 1.0 - initial release
// ============================================================================
module multi_tone_dds #(
  parameter int NCH      = 3,
  parameter int PHASE_W  = 32,
  parameter int LUT_AW   = 10,
  parameter int DATA_W   = 10,
  parameter     LUT_FILE = "sin_qtr.hex",
  localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int SUM_W   = DATA_W + $clog2(NCH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [PHASE_W-1:0]       cfg_inc,
  input  logic                     cfg_en,
  input  logic                     sync_clr,
  output logic [NCH*DATA_W-1:0]    ch_out,
  output logic signed [SUM_W-1:0]  sum_out,
  output logic                     out_valid
);

  // LUT_FILE names the hex image holding exactly the table computed below;
  // the table is generated at elaboration so no external file is needed.
  localparam int c_depth = (2 ** (LUT_AW - 2)) + (0 * $bits(LUT_FILE));
  localparam int c_qa_w  = LUT_AW - 2;

  // rom[i] = round(AMP * sin(2*pi*(i+0.5)/2^LUT_AW)), evaluated in Q30 fixed
  // point with a Taylor series that is accurate well below one output LSB.
  function automatic logic [DATA_W-2:0] rom_val(input int i);
    longint x;
    longint x2;
    longint term;
    longint s;
    longint amp;
    longint v;
    x    = (64'sd3373259426 * longint'(2 * i + 1)) >>> LUT_AW;
    x2   = (x * x) >>> 30;
    term = x;
    s    = x;
    for (int n = 1; n <= 7; n++) begin
      term = (term * x2) >>> 30;
      term = -(term / longint'((2 * n) * (2 * n + 1)));
      s    = s + term;
    end
    amp = longint'((1 << (DATA_W - 1)) - 1);
    v   = (amp * s + (64'sd1 <<< 29)) >>> 30;
    return v[DATA_W-2:0];
  endfunction

  logic [DATA_W-2:0]         w_rom [c_depth];
  logic [c_qa_w-1:0]         w_idx [NCH];
  logic signed [DATA_W-1:0]  w_mag_s [NCH];
  logic signed [SUM_W-1:0]   w_sum;

  logic [PHASE_W-1:0]        r_acc [NCH];
  logic [PHASE_W-1:0]        r_inc [NCH];
  logic [NCH-1:0]            r_en;
  logic [LUT_AW-1:0]         r_p1 [NCH];
  logic [NCH-1:0]            r_en1;
  logic [DATA_W-2:0]         r_mag [NCH];
  logic [NCH-1:0]            r_q2;
  logic [NCH-1:0]            r_en2;
  logic signed [DATA_W-1:0]  r_ch [NCH];
  logic signed [SUM_W-1:0]   r_sum;
  logic [2:0]                r_fill;
  logic                      r_valid;

  for (genvar gi = 0; gi < c_depth; gi++) begin : g_rom
    localparam logic [DATA_W-2:0] c_val = rom_val(gi);
    assign w_rom[gi] = c_val;
  end

  for (genvar gk = 0; gk < NCH; gk++) begin : g_out
    assign ch_out[gk*DATA_W +: DATA_W] = r_ch[gk];
  end

  assign sum_out   = r_sum;
  assign out_valid = r_valid;

  // Store increment/enable for the addressed channel; out-of-range indices match no channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) r_inc[k] <= '0;
      r_en <= '0;
    end else if (cfg_we) begin
      for (int k = 0; k < NCH; k++) begin
        if (int'(cfg_ch) == k) begin
          r_inc[k] <= cfg_inc;
          r_en[k]  <= cfg_en;
        end
      end
    end
  end

  // Phase accumulators: advance when enabled, hold otherwise, align to zero on sync_clr.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (rst || sync_clr) begin
        r_acc[k] <= '0;
      end else if (r_en[k]) begin
        r_acc[k] <= r_acc[k] + r_inc[k];
      end
    end
  end

  // Quadrant fold: the second and fourth quadrants read the table backwards.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      w_idx[k]   = r_p1[k][c_qa_w-1:0] ^ {c_qa_w{r_p1[k][LUT_AW-2]}};
      w_mag_s[k] = $signed({1'b0, r_mag[k]});
    end
  end

  // Three-stage sample pipeline: phase capture, ROM read, sign/enable apply.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        r_p1[k]  <= '0;
        r_mag[k] <= '0;
        r_ch[k]  <= '0;
      end
      r_en1 <= '0;
      r_en2 <= '0;
      r_q2  <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        r_p1[k]  <= r_acc[k][PHASE_W-1 -: LUT_AW];
        r_mag[k] <= w_rom[w_idx[k]];
        r_q2[k]  <= r_p1[k][LUT_AW-1];
        r_ch[k]  <= r_en2[k] ? (r_q2[k] ? -w_mag_s[k] : w_mag_s[k]) : '0;
      end
      r_en1 <= r_en;
      r_en2 <= r_en1;
    end
  end

  // Sign-extend every channel to the sum width before adding, so the sum cannot overflow.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < NCH; k++) begin
      w_sum = w_sum + SUM_W'(r_ch[k]);
    end
  end

  // Output sum register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum <= '0;
    end else begin
      r_sum <= w_sum;
    end
  end

  // Valid rises once the first sum built from cleared accumulators reaches the output.
  always_ff @(posedge clk) begin
    if (rst || sync_clr) begin
      r_fill  <= 3'd0;
      r_valid <= 1'b0;
    end else if (!r_valid) begin
      r_fill  <= r_fill + 3'd1;
      r_valid <= (r_fill == 3'd3);
    end
  end

endmodule
`default_nettype wire
